// File: rtl/exc_commit_unit_if.sv
// CP0 exception/return strobes with cause data, plus the redirect-PC handshake toward fetch.
// The commit unit drives through master; CP0/fetch attach as slave.
interface exc_commit_unit_if;
    logic        interupt;
    logic        cp0_exl;
    logic [31:0] eret_pc;
    logic        execption;
    logic        ret;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badvaddr;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    modport master (
        input  interupt, cp0_exl, eret_pc, redir_ready,
        output execption, ret, exc_code, epc, bd, badvaddr, redir_valid, redir_pc
    );

    modport slave (
        output interupt, cp0_exl, eret_pc, redir_ready,
        input  execption, ret, exc_code, epc, bd, badvaddr, redir_valid, redir_pc
    );
endinterface

// File: rtl/exc_commit_unit.sv
// Precise-exception commit unit: tracks per-instruction exception status ID->EX->MEM and
// commits one exception, interrupt or ERET per event in MEM, then redirects fetch.
module exc_commit_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pipe_adv,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic              id_ri,
    input  logic              id_sys,
    input  logic              id_bp,
    input  logic              id_eret,
    input  logic              id_in_ds,
    input  logic              ex_ov,
    input  logic              mem_adel,
    input  logic              mem_ades,
    input  logic [31:0]       mem_addr,
    output logic              mem_kill,
    output logic              flush,
    exc_commit_unit_if.master cp0
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] badv;
        logic        eret;
    } stage_t;

    typedef enum logic {StRun, StRedir} state_e;

    state_e      state_q, state_d;
    stage_t      id_q, id_d, ex_q, ex_d, mem_q, mem_d;
    stage_t      id_load, ex_load, mem_load;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        int_take, data_err, exc_total;
    logic        exc_fire, ret_fire, commit;

    // Stage loads; a code recorded earlier always survives later stages.
    always_comb begin
        id_load       = '0;
        id_load.valid = if_valid;
        id_load.pc    = if_pc;
        if (if_pc[1:0] != 2'b00) begin
            id_load.exc  = 1'b1;
            id_load.code = 5'd4;
            id_load.badv = if_pc;
        end

        ex_load    = id_q;
        ex_load.bd = id_in_ds;
        if (!id_q.exc) begin
            if (id_ri) begin
                ex_load.exc  = 1'b1;
                ex_load.code = 5'd10;
            end else if (id_sys) begin
                ex_load.exc  = 1'b1;
                ex_load.code = 5'd8;
            end else if (id_bp) begin
                ex_load.exc  = 1'b1;
                ex_load.code = 5'd9;
            end
        end
        ex_load.eret = id_eret & ~ex_load.exc;

        mem_load = ex_q;
        if (!ex_q.exc && ex_ov) begin
            mem_load.exc  = 1'b1;
            mem_load.code = 5'd12;
        end
        mem_load.eret = ex_q.eret & ~mem_load.exc;
    end

    always_comb begin
        int_take  = cp0.interupt & ~cp0.cp0_exl & mem_q.valid;
        data_err  = mem_adel | mem_ades;
        exc_total = mem_q.exc | data_err;
        exc_fire  = (state_q == StRun) & mem_q.valid & (int_take | exc_total);
        ret_fire  = (state_q == StRun) & mem_q.valid & mem_q.eret & ~exc_total & ~int_take;
        commit    = exc_fire | ret_fire;
        mem_kill  = mem_q.valid & (mem_q.exc | int_take | data_err);
    end

    // Cause data is forced to zero whenever no exception strobe is issued.
    always_comb begin
        cp0.execption   = exc_fire;
        cp0.ret         = ret_fire;
        cp0.exc_code    = '0;
        cp0.epc         = '0;
        cp0.bd          = 1'b0;
        cp0.badvaddr    = '0;
        cp0.redir_valid = (state_q == StRedir);
        cp0.redir_pc    = redir_pc_q;
        flush           = commit | (state_q == StRedir);
        if (exc_fire) begin
            cp0.bd  = mem_q.bd;
            cp0.epc = mem_q.bd ? (mem_q.pc - 32'd4) : mem_q.pc;
            if (int_take) begin
                cp0.exc_code = 5'd0;
            end else if (mem_q.exc) begin
                cp0.exc_code = mem_q.code;
                cp0.badvaddr = mem_q.badv;
            end else begin
                cp0.exc_code = mem_adel ? 5'd4 : 5'd5;
                cp0.badvaddr = mem_addr;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ex_d       = ex_q;
        mem_d      = mem_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            StRun: begin
                if (commit) begin
                    state_d    = StRedir;
                    id_d       = '0;
                    ex_d       = '0;
                    mem_d      = '0;
                    redir_pc_d = exc_fire ? EXC_VECTOR : cp0.eret_pc;
                end else if (pipe_adv) begin
                    id_d  = id_load;
                    ex_d  = ex_load;
                    mem_d = mem_load;
                end
            end
            StRedir: begin
                if (cp0.redir_ready) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StRun;
            id_q       <= '0;
            ex_q       <= '0;
            mem_q      <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            redir_pc_q <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_exc_commit_unit.sv
// Self-checking bench for exc_commit_unit: directed scenarios plus randomized single
// instructions checked against a priority-rule reference model.
module tb_exc_commit_unit;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pipe_adv, if_valid, id_ri, id_sys, id_bp, id_eret, id_in_ds;
    logic        ex_ov, mem_adel, mem_ades, mem_kill, flush;
    logic [31:0] if_pc, mem_addr;

    int tests = 0;
    int fails = 0;

    exc_commit_unit_if cif ();

    exc_commit_unit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rstn(rstn), .pipe_adv(pipe_adv), .if_valid(if_valid), .if_pc(if_pc),
        .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_eret(id_eret), .id_in_ds(id_in_ds),
        .ex_ov(ex_ov), .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_addr(mem_addr),
        .mem_kill(mem_kill), .flush(flush), .cp0(cif)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        pipe_adv = 0; if_valid = 0; if_pc = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0;
        id_in_ds = 0; ex_ov = 0; mem_adel = 0; mem_ades = 0; mem_addr = 0;
        cif.interupt = 0; cif.cp0_exl = 0; cif.eret_pc = 0; cif.redir_ready = 0;
    endtask

    // Walks one instruction IF->ID->EX->MEM behind bubbles; returns in its MEM cycle.
    task automatic push_instr(input logic [31:0] pc, input logic ds, ri, sys, bp, er, ov,
                              input logic adel, ades, input logic [31:0] addr,
                              input logic intr, exl);
        @(negedge clk);
        pipe_adv = 1; if_valid = 1; if_pc = pc; cif.interupt = 0; cif.cp0_exl = 0;
        mem_adel = 0; mem_ades = 0;
        @(negedge clk);
        if_valid = 0; if_pc = 0;
        id_ri = ri; id_sys = sys; id_bp = bp; id_eret = er; id_in_ds = ds;
        @(negedge clk);
        id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0; id_in_ds = 0; ex_ov = ov;
        @(negedge clk);
        ex_ov = 0; mem_adel = adel; mem_ades = ades; mem_addr = addr;
        cif.interupt = intr; cif.cp0_exl = exl;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        mem_adel = 0; mem_ades = 0; cif.interupt = 0; cif.cp0_exl = 0;
        #1;
    endtask

    // Holds ready low for delay cycles then raises it; reports what was observed.
    task automatic release_redir(input int delay, output int hi, output logic stable,
                                 output logic strobe, output logic valid_after);
        logic [31:0] pc0;
        hi = 0; stable = 1; strobe = 0; pc0 = cif.redir_pc;
        for (int i = 0; i <= delay; i++) begin
            if (i > 0) @(negedge clk);
            cif.redir_ready = (i == delay);
            #1;
            if (cif.redir_valid) hi++;
            if (cif.redir_pc !== pc0) stable = 0;
            if (cif.execption || cif.ret) strobe = 1;
        end
        @(negedge clk);
        cif.redir_ready = 0;
        #1;
        valid_after = cif.redir_valid;
    endtask

    function automatic void model(input logic [31:0] pc, input logic ds, ri, sys, bp, er, ov,
                                  input logic adel, ades, input logic [31:0] addr,
                                  input logic intr, exl, input logic [31:0] rpc,
                                  output logic e_exc, e_ret, output logic [4:0] e_code,
                                  output logic [31:0] e_epc, e_badv, e_tgt,
                                  output logic e_bd);
        logic [1:0] lo;
        lo = pc[1:0];
        e_exc = 1; e_ret = 0; e_code = 0; e_badv = 0;
        if (intr && !exl) e_code = 0;
        else if (lo != 2'b00) begin e_code = 4; e_badv = pc; end
        else if (ri) e_code = 10;
        else if (sys) e_code = 8;
        else if (bp) e_code = 9;
        else if (ov) e_code = 12;
        else if (adel) begin e_code = 4; e_badv = addr; end
        else if (ades) begin e_code = 5; e_badv = addr; end
        else begin e_exc = 0; e_ret = er; end
        e_bd  = e_exc & ds;
        e_epc = e_exc ? (ds ? pc - 32'd4 : pc) : 32'd0;
        e_tgt = e_exc ? VEC : rpc;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rstn = 0;
        #3;
        tests++; if (cif.execption !== 1'b0) begin fails++; $display("FAIL reset_exc got %b want 0", cif.execption); end
        tests++; if (cif.ret !== 1'b0) begin fails++; $display("FAIL reset_ret got %b want 0", cif.ret); end
        tests++; if (cif.redir_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %b want 0", cif.redir_valid); end
        tests++; if (cif.redir_pc !== 32'd0) begin fails++; $display("FAIL reset_rpc got %h want 0", cif.redir_pc); end
        tests++; if (flush !== 1'b0 || mem_kill !== 1'b0) begin fails++; $display("FAIL reset_flush got %b%b want 00", flush, mem_kill); end
        @(negedge clk); rstn = 1;
    endtask

    task automatic test_overflow();
        int hi; logic st, sb, va;
        push_instr(32'h80001000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tests++; if (cif.execption !== 1'b1) begin fails++; $display("FAIL ov_exc got %b want 1", cif.execption); end
        tests++; if (cif.exc_code !== 5'd12) begin fails++; $display("FAIL ov_code got %0d want 12", cif.exc_code); end
        tests++; if (cif.epc !== 32'h80001000 || cif.bd !== 1'b0) begin fails++; $display("FAIL ov_epc got %h/%b want 80001000/0", cif.epc, cif.bd); end
        tests++; if (flush !== 1'b1 || cif.badvaddr !== 32'd0) begin fails++; $display("FAIL ov_flush got %b/%h want 1/0", flush, cif.badvaddr); end
        next_cycle();
        tests++; if (cif.execption !== 1'b0 || cif.exc_code !== 5'd0) begin fails++; $display("FAIL ov_strobe_len got %b/%0d want 0/0", cif.execption, cif.exc_code); end
        tests++; if (cif.redir_valid !== 1'b1 || cif.redir_pc !== VEC) begin fails++; $display("FAIL ov_redir got %b/%h want 1/%h", cif.redir_valid, cif.redir_pc, VEC); end
        release_redir(2, hi, st, sb, va);
        tests++; if (hi !== 3 || !st || sb || va) begin fails++; $display("FAIL ov_hold got hi=%0d st=%b sb=%b va=%b want 3 1 0 0", hi, st, sb, va); end
    endtask

    task automatic test_syscall_ds();
        int hi; logic st, sb, va;
        push_instr(32'h80002004, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if (cif.exc_code !== 5'd8 || cif.execption !== 1'b1) begin fails++; $display("FAIL sys_code got %0d/%b want 8/1", cif.exc_code, cif.execption); end
        tests++; if (cif.epc !== 32'h80002000 || cif.bd !== 1'b1) begin fails++; $display("FAIL sys_epc got %h/%b want 80002000/1", cif.epc, cif.bd); end
        next_cycle();
        release_redir(0, hi, st, sb, va);
        tests++; if (hi !== 1 || va) begin fails++; $display("FAIL sys_redir got hi=%0d va=%b want 1 0", hi, va); end
    endtask

    task automatic test_addr_err();
        int hi; logic st, sb, va;
        for (int k = 0; k < 2; k++) begin
            push_instr(32'h80002100, 0, 0, 0, 0, 0, 0, k == 0, k == 1, 32'h00000003, 0, 0);
            tests++; if (cif.exc_code !== (k == 0 ? 5'd4 : 5'd5)) begin fails++; $display("FAIL aderr_code got %0d want %0d", cif.exc_code, k == 0 ? 4 : 5); end
            tests++; if (cif.badvaddr !== 32'h3 || mem_kill !== 1'b1) begin fails++; $display("FAIL aderr_badv got %h/%b want 3/1", cif.badvaddr, mem_kill); end
            next_cycle();
            release_redir(1, hi, st, sb, va);
        end
    endtask

    task automatic test_interrupt();
        int hi; logic st, sb, va;
        push_instr(32'h80002200, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tests++; if (cif.exc_code !== 5'd0 || cif.execption !== 1'b1) begin fails++; $display("FAIL int_code got %0d/%b want 0/1", cif.exc_code, cif.execption); end
        next_cycle();
        release_redir(0, hi, st, sb, va);
        push_instr(32'h80002200, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tests++; if (cif.exc_code !== 5'd10 || cif.execption !== 1'b1) begin fails++; $display("FAIL int_masked got %0d/%b want 10/1", cif.exc_code, cif.execption); end
        next_cycle();
        release_redir(0, hi, st, sb, va);
    endtask

    task automatic test_eret();
        int hi; logic st, sb, va;
        cif.eret_pc = 32'h80003010;
        push_instr(32'h80002300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tests++; if (cif.ret !== 1'b1 || cif.execption !== 1'b0) begin fails++; $display("FAIL eret_strobe got %b/%b want 1/0", cif.ret, cif.execption); end
        tests++; if (cif.exc_code !== 5'd0 || mem_kill !== 1'b0 || flush !== 1'b1) begin fails++; $display("FAIL eret_side got %0d/%b/%b want 0/0/1", cif.exc_code, mem_kill, flush); end
        next_cycle();
        tests++; if (cif.ret !== 1'b0 || cif.redir_pc !== 32'h80003010) begin fails++; $display("FAIL eret_redir got %b/%h want 0/80003010", cif.ret, cif.redir_pc); end
        release_redir(3, hi, st, sb, va);
        tests++; if (hi !== 4 || !st || sb || va) begin fails++; $display("FAIL eret_hold got hi=%0d st=%b sb=%b va=%b want 4 1 0 0", hi, st, sb, va); end
    endtask

    task automatic test_no_exc();
        push_instr(32'h80002400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if (cif.execption !== 1'b0 || cif.ret !== 1'b0 || flush !== 1'b0 || mem_kill !== 1'b0) begin fails++; $display("FAIL noexc got %b%b%b%b want 0000", cif.execption, cif.ret, flush, mem_kill); end
        next_cycle();
        tests++; if (cif.redir_valid !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL noexc_after got %b/%b want 0/0", cif.redir_valid, flush); end
    endtask

    task automatic test_back_to_back();
        int hi, strobes; logic st, sb, va;
        @(negedge clk);
        pipe_adv = 1; if_valid = 1; if_pc = 32'h80004000;
        @(negedge clk);
        if_pc = 32'h80004004;
        @(negedge clk);
        if_valid = 0; id_sys = 1; ex_ov = 1;
        @(negedge clk);
        id_sys = 0; ex_ov = 0;
        #1;
        tests++; if (cif.exc_code !== 5'd12 || cif.epc !== 32'h80004000) begin fails++; $display("FAIL b2b_older got %0d/%h want 12/80004000", cif.exc_code, cif.epc); end
        next_cycle();
        release_redir(0, hi, st, sb, va);
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (cif.execption || cif.ret || flush) strobes++;
        end
        tests++; if (strobes !== 0) begin fails++; $display("FAIL b2b_squash got %0d want 0", strobes); end
    endtask

    task automatic test_reset_mid_redir();
        int hi; logic st, sb, va;
        push_instr(32'h80005000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        next_cycle();
        tests++; if (cif.redir_valid !== 1'b1) begin fails++; $display("FAIL rst_pre got %b want 1", cif.redir_valid); end
        #2 rstn = 0;
        #1;
        tests++; if (cif.redir_valid !== 1'b0 || cif.redir_pc !== 32'd0 || flush !== 1'b0 || cif.execption !== 1'b0) begin fails++; $display("FAIL rst_mid got %b/%h/%b/%b want 0/0/0/0", cif.redir_valid, cif.redir_pc, flush, cif.execption); end
        @(negedge clk); rstn = 1;
        push_instr(32'h80006000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++; if (cif.execption !== 1'b1 || cif.exc_code !== 5'd8 || cif.epc !== 32'h80006000) begin fails++; $display("FAIL rst_after got %b/%0d/%h want 1/8/80006000", cif.execption, cif.exc_code, cif.epc); end
        next_cycle();
        release_redir(1, hi, st, sb, va);
    endtask

    task automatic test_random();
        int hi, d; logic st, sb, va;
        logic [31:0] pc, addr, rpc, e_epc, e_badv, e_tgt;
        logic ds, ri, sys, bp, er, ov, adel, ades, intr, exl, e_exc, e_ret, e_bd;
        logic [4:0] e_code;
        for (int n = 0; n < 40; n++) begin
            pc = 32'h80000000 | ($urandom & 32'h000FFFFC);
            if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            ds = 1'($urandom); ri = ($urandom_range(0, 5) == 0); sys = ($urandom_range(0, 5) == 0);
            bp = ($urandom_range(0, 5) == 0); er = ($urandom_range(0, 3) == 0);
            ov = ($urandom_range(0, 5) == 0); adel = ($urandom_range(0, 6) == 0);
            ades = !adel && ($urandom_range(0, 6) == 0); addr = $urandom;
            intr = ($urandom_range(0, 4) == 0); exl = 1'($urandom);
            rpc = $urandom & 32'hFFFFFFFC;
            cif.eret_pc = rpc;
            model(pc, ds, ri, sys, bp, er, ov, adel, ades, addr, intr, exl, rpc,
                  e_exc, e_ret, e_code, e_epc, e_badv, e_tgt, e_bd);
            push_instr(pc, ds, ri, sys, bp, er, ov, adel, ades, addr, intr, exl);
            tests++; if (cif.execption !== e_exc || cif.ret !== e_ret || mem_kill !== e_exc || flush !== (e_exc | e_ret)) begin fails++; $display("FAIL rnd%0d_strobes got %b%b%b%b want %b%b%b%b", n, cif.execption, cif.ret, mem_kill, flush, e_exc, e_ret, e_exc, e_exc | e_ret); end
            tests++; if (cif.exc_code !== e_code || cif.epc !== e_epc || cif.bd !== e_bd || cif.badvaddr !== e_badv) begin fails++; $display("FAIL rnd%0d_cause got %0d/%h/%b/%h want %0d/%h/%b/%h", n, cif.exc_code, cif.epc, cif.bd, cif.badvaddr, e_code, e_epc, e_bd, e_badv); end
            next_cycle();
            if (e_exc || e_ret) begin
                tests++; if (cif.redir_valid !== 1'b1 || cif.redir_pc !== e_tgt) begin fails++; $display("FAIL rnd%0d_redir got %b/%h want 1/%h", n, cif.redir_valid, cif.redir_pc, e_tgt); end
                d = $urandom_range(0, 3);
                release_redir(d, hi, st, sb, va);
                tests++; if (hi !== d + 1 || !st || sb || va) begin fails++; $display("FAIL rnd%0d_hold got hi=%0d st=%b sb=%b va=%b want %0d 1 0 0", n, hi, st, sb, va, d + 1); end
            end else begin
                tests++; if (cif.redir_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_noredir got %b want 0", n, cif.redir_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_syscall_ds();
        test_addr_err();
        test_interrupt();
        test_eret();
        test_no_exc();
        test_back_to_back();
        test_reset_mid_redir();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
